priv_1_12_trap_sequencer: RTL and testbench
===========================================

PRIV_1_12_TRAP_SEQUENCER -- requirements
Module: priv_1_12_trap_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: CLK in 1, clock; RST in 1, synchronous active-high reset.
REQ-002 Parameter RESET_MPP, default 2'b11, is the mstatus.MPP value written on MRET.
REQ-003 SHALL have the following ports:
- exc_flags in 14: mal_insn, fault_insn_access, illegal_insn, breakpoint, fault_l, mal_l, fault_s, mal_s, env_u, env_s, env_m, fault_insn_page, fault_load_page, fault_store_page.
- int_set in 9: interrupt sources {ext,soft,timer}_{m,s,u}.
- int_clr in 9: interrupt-clear sources, same order as int_set.
- ex_rmgmt in 1, ex_rmgmt_cause in $clog2(NUM_EXTENSIONS): RISC-MGMT exception.
- pipe_clear in 1: pipeline drained.
- mret in 1: MRET retiring.
- epc in 32: faulting PC.
- tval in 32: fault address/instruction.
- curr_priv in 2: current privilege.
- curr_mip, curr_mie, curr_mstatus in 32 each: CSR values.
- inject_mip, inject_mcause, inject_mepc, inject_mtval, inject_mstatus out 1 each: CSR write strobes.
- next_mip, next_mcause, next_mepc, next_mtval, next_mstatus out 32 each: CSR write data.
- intr out 1: trap committed this cycle.
- busy out 1: state != IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT_CLEAR, COMMIT, RETURN.
REQ-005 Trap pending SHALL be: any exc_flags bit, or ex_rmgmt, or any (curr_mip & curr_mie) bit with (curr_mstatus.MIE or curr_priv != M).
REQ-006 In IDLE with trap pending: latch cause, epc, tval; go to WAIT_CLEAR. Trap pending has priority over a simultaneous mret.
REQ-007 In IDLE with mret and no trap pending: go to RETURN.
REQ-008 WAIT_CLEAR SHALL hold the latched values, ignore new sources, and go to COMMIT on the first cycle pipe_clear=1.
REQ-009 COMMIT SHALL last exactly 1 cycle, then go to IDLE.
- Asserts intr, inject_mcause, inject_mepc, inject_mtval, inject_mstatus.
- next_mepc = latched epc.
- next_mtval = latched tval for faults/misaligned, else 0.
- next_mstatus = curr_mstatus with MPIE=MIE, MIE=0, MPP=curr_priv.
REQ-010 RETURN SHALL last exactly 1 cycle, then go to IDLE.
- Asserts inject_mstatus only.
- next_mstatus: MIE=MPIE, MPIE=1, MPP=RESET_MPP.
REQ-011 Exceptions SHALL win over interrupts.
- Exception priority: breakpoint > fault_insn_page > fault_insn_access > illegal_insn > mal_insn > env_m > env_s > env_u > mal_s > mal_l > fault_store_page > fault_load_page > fault_s > fault_l > ex_rmgmt.
- Interrupt priority: MEI > MSI > MTI > SEI > SSI > STI > UEI > USI > UTI.
REQ-012 next_mcause[31] SHALL be 1 for an interrupt and 0 for an exception; [30:0] SHALL be the standard RISC-V code.
- env_u/env_s/env_m: codes 8/9/11.
- RISC-MGMT exception: code 24 + ex_rmgmt_cause.
REQ-013 mip maintenance SHALL run in every state, independent of the FSM.
- next_mip = (curr_mip | int_set) & ~int_clr; clear wins.
- inject_mip=1 only when next_mip != curr_mip.
REQ-014 Outputs SHALL be registered-state decoded (Moore); all inject_* and intr SHALL be 0 outside the states named above.
REQ-015 Latency SHALL be: trap detect -> intr is 2 cycles minimum (pipe_clear already high); mret -> inject_mstatus is 1 cycle.

Reset
REQ-016 On RST, in the same clock edge: state=IDLE; latched cause/epc/tval=0; intr, busy and all inject_* = 0; next_* = 0 except next_mip, which follows REQ-013.
REQ-017 RST asserted in WAIT_CLEAR or COMMIT SHALL abandon the trap with no CSR write.

Configuration
REQ-018 Macro TRAP_RMGMT_EN.
- Defined: ex_rmgmt/ex_rmgmt_cause participate per REQ-005/011/012.
- Undefined: those ports are present but ignored, and the RISC-MGMT path is not synthesized.

Structure
REQ-019 The package machine_mode_types_1_12_pkg SHALL hold:
- the trap_state_t enum;
- exception/interrupt cause-code constants;
- the mcause_t, mstatus_t and mip_t field layouts.
REQ-020 Sub-module priv_1_12_trap_prio SHALL be purely combinational, mapping exc_flags/ex_rmgmt/masked interrupts to {valid, is_int, code}.

Verification
REQ-021 illegal_insn=1, epc=0x100, tval=0x0000_0013, pipe_clear=1 -> 2 cycles later: intr=1, mcause=0x2, mepc=0x100, mtval=0x13, mstatus.MIE=0.
REQ-022 MTI pending+enabled, mstatus.MIE=1, priv=M, pipe_clear low for 3 cycles -> intr on cycle 5 with mcause=0x8000_0007.
REQ-023 breakpoint and mal_l together, plus mret, in the same cycle -> mcause=0x3 and no RETURN.
REQ-024 mret with MPIE=1, MIE=0 -> next cycle: inject_mstatus=1, MIE=1, MPIE=1, MPP=RESET_MPP.
REQ-025 int_set=int_clr=MSI bit -> next_mip MSI bit=0.
REQ-026 RST in WAIT_CLEAR -> intr stays 0, busy=0 next cycle.

Source files
------------

// File: rtl/priv_1_12_trap_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : machine_mode_types_1_12_pkg
// Description : Shared types and constants for the machine-mode trap
//               sequencer: FSM state enum, exception/interrupt cause codes,
//               exc_flags bit indices, and mcause/mstatus/mip field layouts.
//               int_set/int_clr bit order (LSB first): timer_u, timer_s,
//               timer_m, soft_u, soft_s, soft_m, ext_u, ext_s, ext_m.
//               Related build macro: TRAP_RMGMT_EN (see priv_1_12_trap_prio).
// Revision    : 1.0 - initial release
// ============================================================================
package machine_mode_types_1_12_pkg;

    localparam int C_NUM_EXTENSIONS = 4;
    localparam int C_RMGMT_CAUSE_W  = $clog2(C_NUM_EXTENSIONS);
    localparam int C_EXC_W          = 14;
    localparam int C_INT_W          = 9;

    localparam logic [1:0] C_PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_CLEAR = 2'd1,
        ST_COMMIT     = 2'd2,
        ST_RETURN     = 2'd3
    } trap_state_t;

    // Bit positions inside exc_flags
    localparam int C_EXC_IDX_MAL_INSN         = 0;
    localparam int C_EXC_IDX_FAULT_INSN_ACC   = 1;
    localparam int C_EXC_IDX_ILLEGAL_INSN     = 2;
    localparam int C_EXC_IDX_BREAKPOINT       = 3;
    localparam int C_EXC_IDX_FAULT_L          = 4;
    localparam int C_EXC_IDX_MAL_L            = 5;
    localparam int C_EXC_IDX_FAULT_S          = 6;
    localparam int C_EXC_IDX_MAL_S            = 7;
    localparam int C_EXC_IDX_ENV_U            = 8;
    localparam int C_EXC_IDX_ENV_S            = 9;
    localparam int C_EXC_IDX_ENV_M            = 10;
    localparam int C_EXC_IDX_FAULT_INSN_PAGE  = 11;
    localparam int C_EXC_IDX_FAULT_LOAD_PAGE  = 12;
    localparam int C_EXC_IDX_FAULT_STORE_PAGE = 13;

    // Standard exception codes (mcause[30:0])
    localparam logic [30:0] C_CAUSE_MAL_INSN         = 31'd0;
    localparam logic [30:0] C_CAUSE_FAULT_INSN_ACC   = 31'd1;
    localparam logic [30:0] C_CAUSE_ILLEGAL_INSN     = 31'd2;
    localparam logic [30:0] C_CAUSE_BREAKPOINT       = 31'd3;
    localparam logic [30:0] C_CAUSE_MAL_L            = 31'd4;
    localparam logic [30:0] C_CAUSE_FAULT_L          = 31'd5;
    localparam logic [30:0] C_CAUSE_MAL_S            = 31'd6;
    localparam logic [30:0] C_CAUSE_FAULT_S          = 31'd7;
    localparam logic [30:0] C_CAUSE_ENV_U            = 31'd8;
    localparam logic [30:0] C_CAUSE_ENV_S            = 31'd9;
    localparam logic [30:0] C_CAUSE_ENV_M            = 31'd11;
    localparam logic [30:0] C_CAUSE_FAULT_INSN_PAGE  = 31'd12;
    localparam logic [30:0] C_CAUSE_FAULT_LOAD_PAGE  = 31'd13;
    localparam logic [30:0] C_CAUSE_FAULT_STORE_PAGE = 31'd15;
    localparam logic [30:0] C_CAUSE_RMGMT_BASE       = 31'd24;

    // mip bit positions; the interrupt cause code equals the bit position
    localparam int C_MIP_USI = 0;
    localparam int C_MIP_SSI = 1;
    localparam int C_MIP_MSI = 3;
    localparam int C_MIP_UTI = 4;
    localparam int C_MIP_STI = 5;
    localparam int C_MIP_MTI = 7;
    localparam int C_MIP_UEI = 8;
    localparam int C_MIP_SEI = 9;
    localparam int C_MIP_MEI = 11;

    typedef struct packed {
        logic        interrupt;
        logic [30:0] code;
    } mcause_t;

    typedef struct packed {
        logic [18:0] rsvd_31_13;
        logic [1:0]  mpp;
        logic [1:0]  rsvd_10_9;
        logic        spp;
        logic        mpie;
        logic        rsvd_6;
        logic        spie;
        logic        upie;
        logic        mie;
        logic        rsvd_2;
        logic        sie;
        logic        uie;
    } mstatus_t;

    typedef struct packed {
        logic [19:0] rsvd_31_12;
        logic        meip;
        logic        rsvd_10;
        logic        seip;
        logic        ueip;
        logic        mtip;
        logic        rsvd_6;
        logic        stip;
        logic        utip;
        logic        msip;
        logic        rsvd_2;
        logic        ssip;
        logic        usip;
    } mip_t;

    // Scatter the compact 9-bit source vector onto mip bit positions
    function automatic logic [31:0] int_vec_to_mip(input logic [C_INT_W-1:0] v);
        logic [31:0] m;
        m            = '0;
        m[C_MIP_UTI] = v[0];
        m[C_MIP_STI] = v[1];
        m[C_MIP_MTI] = v[2];
        m[C_MIP_USI] = v[3];
        m[C_MIP_SSI] = v[4];
        m[C_MIP_MSI] = v[5];
        m[C_MIP_UEI] = v[6];
        m[C_MIP_SEI] = v[7];
        m[C_MIP_MEI] = v[8];
        return m;
    endfunction

    // Exceptions that report an address/instruction in mtval: misaligned,
    // access faults, page faults and illegal instruction.
    function automatic logic cause_has_tval(input logic [30:0] code);
        case (code)
            C_CAUSE_MAL_INSN, C_CAUSE_FAULT_INSN_ACC, C_CAUSE_ILLEGAL_INSN,
            C_CAUSE_MAL_L, C_CAUSE_FAULT_L, C_CAUSE_MAL_S, C_CAUSE_FAULT_S,
            C_CAUSE_FAULT_INSN_PAGE, C_CAUSE_FAULT_LOAD_PAGE,
            C_CAUSE_FAULT_STORE_PAGE: return 1'b1;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/priv_1_12_trap_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : priv_1_12_trap_sequencer_if
// Description : Trap/CSR bundle between the pipeline/CSR file (master) and
//               the trap sequencer (slave).
//               master drives: exc_flags, int_set, int_clr, ex_rmgmt,
//                 ex_rmgmt_cause, pipe_clear, mret, epc, tval, curr_priv,
//                 curr_mip, curr_mie, curr_mstatus
//               slave drives : inject_{mip,mcause,mepc,mtval,mstatus},
//                 next_{mip,mcause,mepc,mtval,mstatus}, intr, busy
// Revision    : 1.0 - initial release
// ============================================================================
interface priv_1_12_trap_sequencer_if;
    import machine_mode_types_1_12_pkg::*;

    logic [C_EXC_W-1:0]         exc_flags;
    logic [C_INT_W-1:0]         int_set;
    logic [C_INT_W-1:0]         int_clr;
    logic                       ex_rmgmt;
    logic [C_RMGMT_CAUSE_W-1:0] ex_rmgmt_cause;
    logic                       pipe_clear;
    logic                       mret;
    logic [31:0]                epc;
    logic [31:0]                tval;
    logic [1:0]                 curr_priv;
    logic [31:0]                curr_mip;
    logic [31:0]                curr_mie;
    logic [31:0]                curr_mstatus;

    logic inject_mip, inject_mcause, inject_mepc, inject_mtval, inject_mstatus;
    logic [31:0] next_mip, next_mcause, next_mepc, next_mtval, next_mstatus;
    logic intr;
    logic busy;

    modport master (
        output exc_flags, int_set, int_clr, ex_rmgmt, ex_rmgmt_cause,
               pipe_clear, mret, epc, tval, curr_priv, curr_mip, curr_mie,
               curr_mstatus,
        input  inject_mip, inject_mcause, inject_mepc, inject_mtval,
               inject_mstatus, next_mip, next_mcause, next_mepc, next_mtval,
               next_mstatus, intr, busy
    );

    modport slave (
        input  exc_flags, int_set, int_clr, ex_rmgmt, ex_rmgmt_cause,
               pipe_clear, mret, epc, tval, curr_priv, curr_mip, curr_mie,
               curr_mstatus,
        output inject_mip, inject_mcause, inject_mepc, inject_mtval,
               inject_mstatus, next_mip, next_mcause, next_mepc, next_mtval,
               next_mstatus, intr, busy
    );

endinterface
`default_nettype wire

// File: rtl/priv_1_12_trap_sequencer_prio.sv
`default_nettype none
// ============================================================================
// Module      : priv_1_12_trap_prio
// Description : Combinational trap arbiter. Picks the highest-priority
//               exception (then RISC-MGMT, then interrupt) and returns
//               {valid, is_int, code}.
//               Ports: exc_flags_i, ex_rmgmt_i, ex_rmgmt_cause_i,
//                      irq_pend_i (mip & mie, already globally gated),
//                      valid_o, is_int_o, code_o.
//               Build macro TRAP_RMGMT_EN: when defined the RISC-MGMT
//               exception participates; otherwise its inputs are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module priv_1_12_trap_prio
    import machine_mode_types_1_12_pkg::*;
(
    input  wire logic [C_EXC_W-1:0]         exc_flags_i,
    input  wire logic                       ex_rmgmt_i,
    input  wire logic [C_RMGMT_CAUSE_W-1:0] ex_rmgmt_cause_i,
    input  wire logic [31:0]                irq_pend_i,
    output logic                            valid_o,
    output logic                            is_int_o,
    output logic [30:0]                     code_o
);

    logic        w_rmgmt;
    logic [30:0] w_rmgmt_code;
    logic        w_unused_irq;

`ifdef TRAP_RMGMT_EN
    assign w_rmgmt      = ex_rmgmt_i;
    assign w_rmgmt_code = C_CAUSE_RMGMT_BASE + 31'(ex_rmgmt_cause_i);
`else
    logic w_unused_rmgmt;
    assign w_rmgmt        = 1'b0;
    assign w_rmgmt_code   = '0;
    assign w_unused_rmgmt = ^{ex_rmgmt_i, ex_rmgmt_cause_i};
`endif

    // mip positions that carry no interrupt source
    assign w_unused_irq = ^{irq_pend_i[31:12], irq_pend_i[10], irq_pend_i[6], irq_pend_i[2]};

    always_comb begin
        valid_o  = 1'b1;
        is_int_o = 1'b0;
        code_o   = '0;
        if      (exc_flags_i[C_EXC_IDX_BREAKPOINT])       code_o = C_CAUSE_BREAKPOINT;
        else if (exc_flags_i[C_EXC_IDX_FAULT_INSN_PAGE])  code_o = C_CAUSE_FAULT_INSN_PAGE;
        else if (exc_flags_i[C_EXC_IDX_FAULT_INSN_ACC])   code_o = C_CAUSE_FAULT_INSN_ACC;
        else if (exc_flags_i[C_EXC_IDX_ILLEGAL_INSN])     code_o = C_CAUSE_ILLEGAL_INSN;
        else if (exc_flags_i[C_EXC_IDX_MAL_INSN])         code_o = C_CAUSE_MAL_INSN;
        else if (exc_flags_i[C_EXC_IDX_ENV_M])            code_o = C_CAUSE_ENV_M;
        else if (exc_flags_i[C_EXC_IDX_ENV_S])            code_o = C_CAUSE_ENV_S;
        else if (exc_flags_i[C_EXC_IDX_ENV_U])            code_o = C_CAUSE_ENV_U;
        else if (exc_flags_i[C_EXC_IDX_MAL_S])            code_o = C_CAUSE_MAL_S;
        else if (exc_flags_i[C_EXC_IDX_MAL_L])            code_o = C_CAUSE_MAL_L;
        else if (exc_flags_i[C_EXC_IDX_FAULT_STORE_PAGE]) code_o = C_CAUSE_FAULT_STORE_PAGE;
        else if (exc_flags_i[C_EXC_IDX_FAULT_LOAD_PAGE])  code_o = C_CAUSE_FAULT_LOAD_PAGE;
        else if (exc_flags_i[C_EXC_IDX_FAULT_S])          code_o = C_CAUSE_FAULT_S;
        else if (exc_flags_i[C_EXC_IDX_FAULT_L])          code_o = C_CAUSE_FAULT_L;
        else if (w_rmgmt)                                 code_o = w_rmgmt_code;
        else if (irq_pend_i[C_MIP_MEI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_MEI); end
        else if (irq_pend_i[C_MIP_MSI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_MSI); end
        else if (irq_pend_i[C_MIP_MTI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_MTI); end
        else if (irq_pend_i[C_MIP_SEI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_SEI); end
        else if (irq_pend_i[C_MIP_SSI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_SSI); end
        else if (irq_pend_i[C_MIP_STI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_STI); end
        else if (irq_pend_i[C_MIP_UEI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_UEI); end
        else if (irq_pend_i[C_MIP_USI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_USI); end
        else if (irq_pend_i[C_MIP_UTI]) begin is_int_o = 1'b1; code_o = 31'(C_MIP_UTI); end
        else                                              valid_o = 1'b0;
    end

endmodule
`default_nettype wire

// File: rtl/priv_1_12_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : priv_1_12_trap_sequencer
// Description : Machine-mode trap sequencer. Captures a pending trap, waits
//               for the pipeline to drain, then commits mcause/mepc/mtval/
//               mstatus in one cycle; also sequences MRET and maintains mip.
//               Ports: clk, rst (sync, active high), bus_io (slave modport
//               of priv_1_12_trap_sequencer_if).
//               Parameter RESET_MPP: mstatus.MPP value written on MRET.
//               Build macro TRAP_RMGMT_EN enables the RISC-MGMT exception.
// Revision    : 1.0 - initial release
// ============================================================================
module priv_1_12_trap_sequencer
    import machine_mode_types_1_12_pkg::*;
#(
    parameter logic [1:0] RESET_MPP = 2'b11
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    priv_1_12_trap_sequencer_if.slave bus_io
);

    trap_state_t state_q, state_d;
    mcause_t     cause_q;
    logic [31:0] epc_q;
    logic [31:0] tval_q;

    logic        w_int_en;
    logic [31:0] w_irq_pend;
    logic        w_valid;
    logic        w_is_int;
    logic [30:0] w_code;
    logic [31:0] w_next_mip;
    mstatus_t    w_mst_cur;
    mstatus_t    w_mst_out;

    assign w_mst_cur  = mstatus_t'(bus_io.curr_mstatus);
    // Interrupts are globally enabled in M-mode only by mstatus.MIE, and
    // always enabled when running below M-mode.
    assign w_int_en   = w_mst_cur.mie || (bus_io.curr_priv != C_PRIV_M);
    assign w_irq_pend = w_int_en ? (bus_io.curr_mip & bus_io.curr_mie) : '0;

    priv_1_12_trap_prio u_prio (
        .exc_flags_i      (bus_io.exc_flags),
        .ex_rmgmt_i       (bus_io.ex_rmgmt),
        .ex_rmgmt_cause_i (bus_io.ex_rmgmt_cause),
        .irq_pend_i       (w_irq_pend),
        .valid_o          (w_valid),
        .is_int_o         (w_is_int),
        .code_o           (w_code)
    );

    // mip maintenance is independent of the FSM; clear beats set
    assign w_next_mip        = (bus_io.curr_mip | int_vec_to_mip(bus_io.int_set))
                               & ~int_vec_to_mip(bus_io.int_clr);
    assign bus_io.next_mip   = w_next_mip;
    assign bus_io.inject_mip = (w_next_mip != bus_io.curr_mip);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Trap capture: only in IDLE, so later sources are ignored while waiting.
    // mtval is qualified at capture so COMMIT just replays the register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
        end else if (state_q == ST_IDLE && w_valid) begin
            cause_q <= '{interrupt: w_is_int, code: w_code};
            epc_q   <= bus_io.epc;
            tval_q  <= (!w_is_int && cause_has_tval(w_code)) ? bus_io.tval : '0;
        end
    end

    // Next-state logic; a pending trap outranks a simultaneous MRET
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_valid)          state_d = ST_WAIT_CLEAR;
                else if (bus_io.mret) state_d = ST_RETURN;
            end
            ST_WAIT_CLEAR: begin
                if (bus_io.pipe_clear) state_d = ST_COMMIT;
            end
            ST_COMMIT:     state_d = ST_IDLE;
            ST_RETURN:     state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        bus_io.intr           = 1'b0;
        bus_io.busy           = (state_q != ST_IDLE);
        bus_io.inject_mcause  = 1'b0;
        bus_io.inject_mepc    = 1'b0;
        bus_io.inject_mtval   = 1'b0;
        bus_io.inject_mstatus = 1'b0;
        bus_io.next_mcause    = '0;
        bus_io.next_mepc      = '0;
        bus_io.next_mtval     = '0;
        bus_io.next_mstatus   = '0;
        w_mst_out             = w_mst_cur;
        case (state_q)
            ST_COMMIT: begin
                bus_io.intr           = 1'b1;
                bus_io.inject_mcause  = 1'b1;
                bus_io.inject_mepc    = 1'b1;
                bus_io.inject_mtval   = 1'b1;
                bus_io.inject_mstatus = 1'b1;
                bus_io.next_mcause    = cause_q;
                bus_io.next_mepc      = epc_q;
                bus_io.next_mtval     = tval_q;
                w_mst_out.mpie        = w_mst_cur.mie;
                w_mst_out.mie         = 1'b0;
                w_mst_out.mpp         = bus_io.curr_priv;
                bus_io.next_mstatus   = w_mst_out;
            end
            ST_RETURN: begin
                bus_io.inject_mstatus = 1'b1;
                w_mst_out.mie         = w_mst_cur.mpie;
                w_mst_out.mpie        = 1'b1;
                w_mst_out.mpp         = RESET_MPP;
                bus_io.next_mstatus   = w_mst_out;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_priv_1_12_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_priv_1_12_trap_sequencer
// Description : Self-checking bench for priv_1_12_trap_sequencer. A
//               transaction-level reference model predicts every output on
//               every cycle; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priv_1_12_trap_sequencer;

    localparam logic [1:0] RESET_MPP = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    priv_1_12_trap_sequencer_if ifc ();

    priv_1_12_trap_sequencer #(.RESET_MPP(RESET_MPP)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (ifc)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Exception flag bits listed from highest to lowest priority
    int exc_order[14] = '{3, 11, 1, 2, 0, 10, 9, 8, 7, 5, 13, 12, 6, 4};
    // RISC-V code for each exc_flags bit
    int exc_code[14]  = '{0, 1, 2, 3, 5, 4, 7, 6, 8, 9, 11, 12, 13, 15};
    // mip bits from highest to lowest priority (code == bit index)
    int irq_order[9]  = '{11, 3, 7, 9, 1, 5, 8, 0, 4};
    // mip bit targeted by each int_set/int_clr bit
    int set_pos[9]    = '{4, 5, 7, 0, 1, 3, 8, 9, 11};

    bit          m_wait, m_commit, m_ret;
    logic [31:0] m_cause, m_epc, m_tval;

    function automatic void ref_trap(output bit found, output logic [31:0] cause,
                                     output logic [31:0] tv);
        logic [31:0] pend;
        found = 1'b0;
        cause = '0;
        tv    = '0;
        for (int i = 0; i < 14; i++)
            if (!found && ifc.exc_flags[exc_order[i]]) begin
                found = 1'b1;
                cause = 32'(exc_code[exc_order[i]]);
            end
`ifdef TRAP_RMGMT_EN
        if (!found && ifc.ex_rmgmt) begin
            found = 1'b1;
            cause = 32'd24 + 32'(ifc.ex_rmgmt_cause);
        end
`endif
        if (found) begin
            if (cause inside {0, 1, 2, 4, 5, 6, 7, 12, 13, 15}) tv = ifc.tval;
        end else if (ifc.curr_mstatus[3] || ifc.curr_priv != 2'b11) begin
            pend = ifc.curr_mip & ifc.curr_mie;
            for (int i = 0; i < 9; i++)
                if (!found && pend[irq_order[i]]) begin
                    found = 1'b1;
                    cause = 32'h8000_0000 | 32'(irq_order[i]);
                end
        end
    endfunction

    always @(posedge clk) begin : model_upd
        bit          f;
        logic [31:0] c, t;
        ref_trap(f, c, t);
        if (rst) begin
            m_wait <= 1'b0; m_commit <= 1'b0; m_ret <= 1'b0;
            m_cause <= '0; m_epc <= '0; m_tval <= '0;
        end else if (m_commit || m_ret) begin
            m_commit <= 1'b0;
            m_ret    <= 1'b0;
        end else if (m_wait) begin
            if (ifc.pipe_clear) begin
                m_wait   <= 1'b0;
                m_commit <= 1'b1;
            end
        end else if (f) begin
            m_wait  <= 1'b1;
            m_cause <= c;
            m_epc   <= ifc.epc;
            m_tval  <= t;
        end else if (ifc.mret) begin
            m_ret <= 1'b1;
        end
    end

    always @(negedge clk) if (cmp_en) begin : cmp
        logic [31:0] e_mip, e_mst;
        e_mip = ifc.curr_mip;
        for (int i = 0; i < 9; i++) if (ifc.int_set[i]) e_mip[set_pos[i]] = 1'b1;
        for (int i = 0; i < 9; i++) if (ifc.int_clr[i]) e_mip[set_pos[i]] = 1'b0;
        e_mst = '0;
        if (m_commit) begin
            e_mst        = ifc.curr_mstatus;
            e_mst[7]     = ifc.curr_mstatus[3];
            e_mst[3]     = 1'b0;
            e_mst[12:11] = ifc.curr_priv;
        end else if (m_ret) begin
            e_mst        = ifc.curr_mstatus;
            e_mst[3]     = ifc.curr_mstatus[7];
            e_mst[7]     = 1'b1;
            e_mst[12:11] = RESET_MPP;
        end
        check("intr",           32'(ifc.intr),           32'(m_commit));
        check("busy",           32'(ifc.busy),           32'(m_wait | m_commit | m_ret));
        check("inject_mcause",  32'(ifc.inject_mcause),  32'(m_commit));
        check("inject_mepc",    32'(ifc.inject_mepc),    32'(m_commit));
        check("inject_mtval",   32'(ifc.inject_mtval),   32'(m_commit));
        check("inject_mstatus", 32'(ifc.inject_mstatus), 32'(m_commit | m_ret));
        check("next_mcause",    ifc.next_mcause,         m_commit ? m_cause : 32'h0);
        check("next_mepc",      ifc.next_mepc,           m_commit ? m_epc : 32'h0);
        check("next_mtval",     ifc.next_mtval,          m_commit ? m_tval : 32'h0);
        check("next_mstatus",   ifc.next_mstatus,        e_mst);
        check("next_mip",       ifc.next_mip,            e_mip);
        check("inject_mip",     32'(ifc.inject_mip),     32'(e_mip != ifc.curr_mip));
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        ifc.exc_flags      = '0;
        ifc.int_set        = '0;
        ifc.int_clr        = '0;
        ifc.ex_rmgmt       = 1'b0;
        ifc.ex_rmgmt_cause = '0;
        ifc.pipe_clear     = 1'b1;
        ifc.mret           = 1'b0;
        ifc.epc            = '0;
        ifc.tval           = '0;
        ifc.curr_priv      = 2'b11;
        ifc.curr_mip       = '0;
        ifc.curr_mie       = '0;
        ifc.curr_mstatus   = '0;
    endtask

    initial begin
        idle();
        ifc.curr_mstatus = 32'h8;
        rst = 1'b1;
        step(1);
        cmp_en = 1'b1;
        check("rst_busy",         32'(ifc.busy), 32'h0);
        check("rst_intr",         32'(ifc.intr), 32'h0);
        check("rst_next_mstatus", ifc.next_mstatus, 32'h0);
        check("rst_next_mcause",  ifc.next_mcause, 32'h0);
        step(1);
        rst = 1'b0;
        idle();
        step(1);

        // Illegal instruction, pipeline already drained
        ifc.exc_flags = 14'h0004; ifc.epc = 32'h100; ifc.tval = 32'h13; ifc.curr_mstatus = 32'h8;
        step(1);
        check("ill_busy", 32'(ifc.busy), 32'h1);
        ifc.exc_flags = '0; ifc.epc = 32'hDEAD; ifc.tval = 32'hBEEF;
        step(1);
        check("ill_intr",    32'(ifc.intr), 32'h1);
        check("ill_mcause",  ifc.next_mcause, 32'h2);
        check("ill_mepc",    ifc.next_mepc, 32'h100);
        check("ill_mtval",   ifc.next_mtval, 32'h13);
        check("ill_mstatus", ifc.next_mstatus, 32'h0000_1880);
        idle();
        step(2);

        // Machine timer interrupt, drain delayed three cycles
        ifc.curr_mip = 32'h80; ifc.curr_mie = 32'h80; ifc.curr_mstatus = 32'h8; ifc.pipe_clear = 1'b0;
        step(4);
        check("mti_wait_intr", 32'(ifc.intr), 32'h0);
        check("mti_wait_busy", 32'(ifc.busy), 32'h1);
        ifc.pipe_clear = 1'b1;
        step(1);
        check("mti_intr",   32'(ifc.intr), 32'h1);
        check("mti_mcause", ifc.next_mcause, 32'h8000_0007);
        idle();
        step(2);

        // Breakpoint + misaligned load + mret together
        ifc.exc_flags = 14'h0028; ifc.mret = 1'b1; ifc.tval = 32'h44;
        step(1);
        check("bp_no_return", 32'(ifc.inject_mstatus), 32'h0);
        ifc.exc_flags = '0; ifc.mret = 1'b0;
        step(1);
        check("bp_mcause", ifc.next_mcause, 32'h3);
        check("bp_mtval",  ifc.next_mtval, 32'h0);
        idle();
        step(2);

        // MRET with MPIE=1, MIE=0
        ifc.curr_mstatus = 32'h80; ifc.mret = 1'b1;
        step(1);
        ifc.mret = 1'b0;
        check("mret_inject",  32'(ifc.inject_mstatus), 32'h1);
        check("mret_mstatus", ifc.next_mstatus, 32'h0000_1888);
        check("mret_no_intr", 32'(ifc.intr), 32'h0);
        step(1);
        check("mret_done", 32'(ifc.inject_mstatus), 32'h0);
        idle();
        step(1);

        // mip maintenance
        ifc.int_set = 9'h020; ifc.int_clr = 9'h020; #1;
        check("msi_clr_wins", ifc.next_mip, 32'h0);
        check("msi_clr_noinj", 32'(ifc.inject_mip), 32'h0);
        ifc.int_clr = '0; #1;
        check("msi_set", ifc.next_mip, 32'h8);
        check("msi_set_inj", 32'(ifc.inject_mip), 32'h1);
        ifc.curr_mip = 32'h80; ifc.int_set = '0; ifc.int_clr = 9'h004; #1;
        check("mti_clr", ifc.next_mip, 32'h0);
        idle();
        step(1);

        // Reset while waiting for the drain abandons the trap
        ifc.exc_flags = 14'h0004; ifc.pipe_clear = 1'b0;
        step(1);
        check("rw_busy", 32'(ifc.busy), 32'h1);
        rst = 1'b1;
        step(1);
        check("rw_busy_after", 32'(ifc.busy), 32'h0);
        check("rw_intr_after", 32'(ifc.intr), 32'h0);
        rst = 1'b0;
        idle();
        step(3);

        // Below M-mode interrupts fire regardless of MIE; MEI beats MTI
        ifc.curr_mip = 32'h880; ifc.curr_mie = 32'h880; ifc.curr_priv = 2'b00;
        step(1);
        ifc.curr_mip = '0;
        step(1);
        check("umode_mcause", ifc.next_mcause, 32'h8000_000B);
        idle();
        step(2);

        // M-mode with MIE=0 masks the interrupt
        ifc.curr_mip = 32'h80; ifc.curr_mie = 32'h80;
        step(2);
        check("masked_busy", 32'(ifc.busy), 32'h0);
        idle();

        // RISC-MGMT exception
        ifc.ex_rmgmt = 1'b1; ifc.ex_rmgmt_cause = 2'd1;
        step(1);
`ifdef TRAP_RMGMT_EN
        check("rmgmt_busy", 32'(ifc.busy), 32'h1);
        ifc.ex_rmgmt = 1'b0;
        step(1);
        check("rmgmt_mcause", ifc.next_mcause, 32'd25);
`else
        check("rmgmt_ignored", 32'(ifc.busy), 32'h0);
`endif
        idle();
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
